// File: rtl/adc_period_timer_if.sv
// Bus between the AD7928 driver side and the period timer: the raw ADC word in,
// the filtered level, the programmed period and the tick outputs back.
interface adc_period_timer_if;
   logic [11:0] adc_data;
   logic [11:0] level;
   logic        level_valid;
   logic [31:0] period;
   logic        tick;
   logic        square;

   modport master (
      output adc_data,
      input  level,
      input  level_valid,
      input  period,
      input  tick,
      input  square
   );

   modport slave (
      input  adc_data,
      output level,
      output level_valid,
      output period,
      output tick,
      output square
   );
endinterface

// File: rtl/adc_period_timer.sv
// Turns the potentiometer reading from the ADC driver into a programmable tick
// period: decimated sampling, boxcar average, hysteresis, linear map, period counter.
module adc_period_timer #(
   parameter int unsigned SAMPLE_DIV = 68,
   parameter int unsigned AVG_LOG2   = 3,
   parameter int unsigned HYST       = 8,
   parameter int unsigned BASE       = 50000,
   parameter int unsigned STEP       = 1000
) (
   input  logic               clock,
   input  logic               reset,
   adc_period_timer_if.slave  bus
);

   localparam int unsigned AW = 12 + AVG_LOG2;
   localparam int unsigned NW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
   localparam int unsigned SW = $clog2(SAMPLE_DIV);
   localparam logic [SW-1:0] SDIV_LAST = SW'(SAMPLE_DIV - 1);
   localparam logic [NW-1:0] N_LAST    = NW'((1 << AVG_LOG2) - 1);

   logic [SW-1:0] sdiv_q, sdiv_d;
   logic [NW-1:0] n_q, n_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [11:0]   avgReg_q, avgReg_d;
   logic          avgVld_q, avgVld_d;
   logic [11:0]   level_q, level_d;
   logic          levelValid_q, levelValid_d;
   logic          primed_q, primed_d;
   logic [31:0]   period_q, period_d;
   logic [31:0]   pcnt_q, pcnt_d;
   logic          tick_q, tick_d;
   logic          square_q, square_d;

   logic          sampleEn;
   logic          lastSample;
   logic [AW-1:0] sampleSum;
   logic signed [12:0] diff;
   logic [12:0]   absDiff;
   logic          periodEnd;

   // Sample divider and boxcar accumulator; the final sample of a block is folded
   // straight into the average so the accumulator never needs an extra cycle.
   always_comb begin
      sampleEn   = (sdiv_q == SDIV_LAST);
      lastSample = (n_q == N_LAST);
      sampleSum  = acc_q + AW'(bus.adc_data);
      sdiv_d     = sampleEn ? '0 : sdiv_q + SW'(1);
      n_d        = n_q;
      acc_d      = acc_q;
      avgReg_d   = avgReg_q;
      avgVld_d   = 1'b0;
      if (sampleEn) begin
         if (lastSample) begin
            n_d      = '0;
            acc_d    = '0;
            avgReg_d = 12'(sampleSum >> AVG_LOG2);
            avgVld_d = 1'b1;
         end else begin
            n_d   = n_q + NW'(1);
            acc_d = sampleSum;
         end
      end
   end

   // Hysteresis: the first average after reset is always accepted, later ones
   // only if they move far enough from the held level.
   always_comb begin
      diff         = $signed({1'b0, avgReg_q}) - $signed({1'b0, level_q});
      absDiff      = diff[12] ? 13'(-diff) : 13'(diff);
      level_d      = level_q;
      levelValid_d = 1'b0;
      primed_d     = primed_q;
      if (avgVld_q && (primed_q || (absDiff >= 13'(HYST)))) begin
         level_d      = avgReg_q;
         levelValid_d = 1'b1;
         primed_d     = 1'b0;
      end
   end

   // The end-of-period compare uses the period register before any update on this
   // edge, so a new period only takes effect from the following cycle.
   always_comb begin
      period_d  = levelValid_q ? (BASE + 32'(level_q) * STEP) : period_q;
      periodEnd = (pcnt_q >= (period_q - 32'd1));
      pcnt_d    = periodEnd ? 32'd0 : pcnt_q + 32'd1;
      tick_d    = periodEnd;
      square_d  = periodEnd ? ~square_q : square_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sdiv_q       <= '0;
         n_q          <= '0;
         acc_q        <= '0;
         avgReg_q     <= '0;
         avgVld_q     <= 1'b0;
         level_q      <= '0;
         levelValid_q <= 1'b0;
         primed_q     <= 1'b1;
         period_q     <= BASE;
         pcnt_q       <= '0;
         tick_q       <= 1'b0;
         square_q     <= 1'b0;
      end else begin
         sdiv_q       <= sdiv_d;
         n_q          <= n_d;
         acc_q        <= acc_d;
         avgReg_q     <= avgReg_d;
         avgVld_q     <= avgVld_d;
         level_q      <= level_d;
         levelValid_q <= levelValid_d;
         primed_q     <= primed_d;
         period_q     <= period_d;
         pcnt_q       <= pcnt_d;
         tick_q       <= tick_d;
         square_q     <= square_d;
      end
   end

   assign bus.level       = level_q;
   assign bus.level_valid = levelValid_q;
   assign bus.period      = period_q;
   assign bus.tick        = tick_q;
   assign bus.square      = square_q;

endmodule

// File: tb/tb_adc_period_timer.sv
// Bench for adc_period_timer: directed scenarios plus random ADC traffic, checked
// every cycle against an edge-indexed behavioural model of sampling, averaging and ticks.
module tb_adc_period_timer;

   localparam int SD    = 4;
   localparam int ALOG  = 2;
   localparam int HYST  = 8;
   localparam int BASE  = 10;
   localparam int STEP  = 1;
   localparam int BLOCK = 1 << ALOG;

   logic clock;
   logic reset;
   int   checkCount;
   int   errorCount;

   adc_period_timer_if bus ();

   adc_period_timer #(
      .SAMPLE_DIV (SD),
      .AVG_LOG2   (ALOG),
      .HYST       (HYST),
      .BASE       (BASE),
      .STEP       (STEP)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, observed, expected);
      end
   endtask

   // Reference model state: k is the edge index since reset release, ticks are
   // placed P edges after the previous tick, averages are plain integer means.
   int  mK, mLastTick, mPeriod, mLevel, mAvg, mSum;
   int  nPeriod, nLevel;
   bit  mArmed, mLv, mAvgVld, mPrimed, mTick, mSquare;
   bit  nLv, nAvgVld;
   int  mSamples[$];

   initial mArmed = 1'b0;

   always @(posedge clock) begin
      if (reset) begin
         mArmed    = 1'b1;
         mK        = 0;
         mLastTick = 0;
         mPeriod   = BASE;
         mLevel    = 0;
         mAvg      = 0;
         mLv       = 1'b0;
         mAvgVld   = 1'b0;
         mPrimed   = 1'b1;
         mTick     = 1'b0;
         mSquare   = 1'b0;
         mSamples.delete();
      end else if (mArmed) begin
         mK++;
         mTick = ((mK - mLastTick) >= mPeriod);
         if (mTick) begin
            mLastTick = mK;
            mSquare   = !mSquare;
         end
         nPeriod = mLv ? (BASE + mLevel * STEP) : mPeriod;
         nLv     = 1'b0;
         nLevel  = mLevel;
         if (mAvgVld && (mPrimed || ((mAvg > mLevel ? mAvg - mLevel : mLevel - mAvg) >= HYST))) begin
            nLevel  = mAvg;
            nLv     = 1'b1;
            mPrimed = 1'b0;
         end
         nAvgVld = 1'b0;
         if ((mK % SD) == 0) begin
            mSamples.push_back(int'(bus.adc_data));
            if (mSamples.size() == BLOCK) begin
               mSum = 0;
               foreach (mSamples[i]) mSum += mSamples[i];
               mAvg    = mSum / BLOCK;
               nAvgVld = 1'b1;
               mSamples.delete();
            end
         end
         mAvgVld = nAvgVld;
         mLevel  = nLevel;
         mLv     = nLv;
         mPeriod = nPeriod;
      end
      if (mArmed) begin
         #1;
         checkOutput("level", 32'(bus.level), 32'(mLevel));
         checkOutput("level_valid", 32'(bus.level_valid), 32'(mLv));
         checkOutput("period", bus.period, 32'(mPeriod));
         checkOutput("tick", 32'(bus.tick), 32'(mTick));
         checkOutput("square", 32'(bus.square), 32'(mSquare));
      end
   end

   // Holds adc_data for a number of edges; called at a falling edge, returns at one.
   task automatic applyStimulus(input int value, input int cycles);
      bus.adc_data = 12'(value);
      repeat (cycles) @(negedge clock);
   endtask

   task automatic doReset();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   int value, len;

   initial begin
      checkCount   = 0;
      errorCount   = 0;
      reset        = 1'b1;
      bus.adc_data = 12'd0;
      repeat (3) @(negedge clock);

      // Idle: first level load at edge 17, period stays at BASE.
      reset = 1'b0;
      applyStimulus(0, 17);
      checkOutput("idle_lv17", 32'(bus.level_valid), 32'd1);
      checkOutput("idle_level17", 32'(bus.level), 32'd0);
      applyStimulus(0, 1);
      checkOutput("idle_lv18", 32'(bus.level_valid), 32'd0);
      checkOutput("idle_period18", bus.period, 32'd10);
      applyStimulus(0, 42);

      // Constant 100, then shortening the period to 20 mid-count.
      doReset();
      applyStimulus(100, 17);
      checkOutput("const_level17", 32'(bus.level), 32'd100);
      applyStimulus(100, 1);
      checkOutput("const_period18", bus.period, 32'd110);
      applyStimulus(100, 30);
      applyStimulus(10, 18);
      checkOutput("short_period66", bus.period, 32'd20);
      checkOutput("short_tick66", 32'(bus.tick), 32'd0);
      applyStimulus(10, 1);
      checkOutput("short_tick67", 32'(bus.tick), 32'd1);
      applyStimulus(10, 20);
      checkOutput("short_tick87", 32'(bus.tick), 32'd1);

      // Hysteresis around 100.
      doReset();
      applyStimulus(100, 40);
      applyStimulus(107, 64);
      checkOutput("hyst_107", 32'(bus.level), 32'd100);
      applyStimulus(108, 48);
      checkOutput("hyst_108", 32'(bus.level), 32'd108);
      applyStimulus(92, 48);
      checkOutput("hyst_92", 32'(bus.level), 32'd92);

      // Truncating average and the full-scale boundary.
      doReset();
      applyStimulus(1, 4);
      applyStimulus(2, 13);
      checkOutput("trunc_level", 32'(bus.level), 32'd1);
      applyStimulus(2, 1);
      checkOutput("trunc_period", bus.period, 32'd11);
      applyStimulus(4095, 64);
      checkOutput("full_level", 32'(bus.level), 32'd4095);
      checkOutput("full_period", bus.period, 32'd4105);

      // Reset after two samples of a block; a small level is accepted while primed.
      doReset();
      applyStimulus(500, 8);
      doReset();
      applyStimulus(3, 16);
      checkOutput("midrst_lv16", 32'(bus.level_valid), 32'd0);
      applyStimulus(3, 1);
      checkOutput("midrst_lv17", 32'(bus.level_valid), 32'd1);
      checkOutput("midrst_level17", 32'(bus.level), 32'd3);

      // Random traffic: large jumps, small nudges near the hysteresis band, resets.
      value = 200;
      repeat (60) begin
         if ($urandom_range(0, 9) == 0) doReset();
         if ($urandom_range(0, 1) == 0) begin
            value = int'($urandom_range(0, 4095));
         end else begin
            value = value + int'($urandom_range(0, 24)) - 12;
            if (value < 0) value = 0;
            if (value > 4095) value = 4095;
         end
         len = int'($urandom_range(1, 60));
         applyStimulus(value, len);
      end
      applyStimulus(value, 40);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
